// File: rtl/ex_pkg.sv
// ex_pkg: types and constants shared by the EX/MEM stage and the
// fetch-stage predictor checker.
//   BR_EQ..BR_AL : 3-bit branch condition encodings
//   cc_t         : condition-code register {z, v, n}
//   ex_mem_t     : payload carried from EX into MEM
// The payload widths are fixed here; the DW and RW parameters of
// ex_mem_stage must match EX_DW and EX_RW.
package ex_pkg;

  localparam int EX_DW = 16;
  localparam int EX_RW = 3;

  localparam logic [2:0] BR_EQ = 3'd0;
  localparam logic [2:0] BR_NE = 3'd1;
  localparam logic [2:0] BR_LT = 3'd2;
  localparam logic [2:0] BR_GE = 3'd3;
  localparam logic [2:0] BR_GT = 3'd4;
  localparam logic [2:0] BR_LE = 3'd5;
  localparam logic [2:0] BR_OV = 3'd6;
  localparam logic [2:0] BR_AL = 3'd7;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } cc_t;

  typedef struct packed {
    logic [EX_DW-1:0] result;
    logic [EX_DW-1:0] store_data;
    logic [EX_RW-1:0] rd;
    logic             reg_we;
    logic             mem_re;
    logic             mem_we;
  } ex_mem_t;

endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: purely combinational branch-condition resolver.
//   cc    in  cc_t   condition codes to test
//   cond  in  3      condition encoding (BR_EQ..BR_AL)
//   taken out 1      condition holds
module br_cond_eval
  import ex_pkg::*;
(
  input  cc_t        cc,
  input  logic [2:0] cond,
  output logic       taken
);

  logic lt;

  // Signed less-than after a compare: negative result unless overflowed.
  assign lt = cc.n ^ cc.v;

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      BR_EQ:   taken = cc.z;
      BR_NE:   taken = ~cc.z;
      BR_LT:   taken = lt;
      BR_GE:   taken = ~lt;
      BR_GT:   taken = ~cc.z & ~lt;
      BR_LE:   taken = cc.z | lt;
      BR_OV:   taken = cc.v;
      BR_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: one-entry valid/ready pipeline register between the
// ALU and the memory stage. Also owns the condition-code register and
// resolves branches against it, pulsing redirect for one cycle when a
// branch is taken.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        upstream handshake
//   in_result, in_z/v/n        ALU result and flags
//   in_flag_we                 instruction updates CC
//   in_is_branch, in_br_cond,
//   in_br_target               branch description
//   in_rd, in_reg_we, in_mem_re,
//   in_mem_we, in_store_data   payload to the memory stage
//   flush                      squash from a later-stage exception
//   out_valid / out_ready      downstream handshake
//   out_result, out_store_data,
//   out_rd, out_reg_we,
//   out_mem_re, out_mem_we     registered payload (controls masked by out_valid)
//   cc_z, cc_v, cc_n           current CC register
//   redirect, redirect_pc      one-cycle taken-branch redirect
// Optional: define EX_MEM_PERF_EN to add perf_stall, perf_taken and
// perf_flush 16-bit wrapping event counters.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic          in_z,
  input  logic          in_v,
  input  logic          in_n,
  input  logic          in_flag_we,
  input  logic          in_is_branch,
  input  logic [2:0]    in_br_cond,
  input  logic [DW-1:0] in_br_target,
  input  logic [RW-1:0] in_rd,
  input  logic          in_reg_we,
  input  logic          in_mem_re,
  input  logic          in_mem_we,
  input  logic [DW-1:0] in_store_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [DW-1:0] out_store_data,
  output logic [RW-1:0] out_rd,
  output logic          out_reg_we,
  output logic          out_mem_re,
  output logic          out_mem_we,
  output logic          cc_z,
  output logic          cc_v,
  output logic          cc_n,
  output logic          redirect,
  output logic [DW-1:0] redirect_pc
`ifdef EX_MEM_PERF_EN
  ,
  output logic [15:0]   perf_stall,
  output logic [15:0]   perf_taken,
  output logic [15:0]   perf_flush
`endif
);

  logic          valid_q, valid_d;
  ex_mem_t       payload_q, payload_d;
  cc_t           cc_q, cc_d;
  logic          redirect_q, redirect_d;
  logic [DW-1:0] redirect_pc_q, redirect_pc_d;
  logic          accept;
  logic          cond_true;

  // Evaluated against the CC as it stands before this instruction.
  br_cond_eval u_br_cond_eval (
    .cc    (cc_q),
    .cond  (in_br_cond),
    .taken (cond_true)
  );

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    valid_d       = valid_q;
    payload_d     = payload_q;
    cc_d          = cc_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d              = 1'b1;
      payload_d.result     = in_result;
      payload_d.store_data = in_store_data;
      payload_d.rd         = in_rd;
      payload_d.reg_we     = in_reg_we;
      payload_d.mem_re     = in_mem_re;
      payload_d.mem_we     = in_mem_we;
      // Branches never write flags, even if flag_we is set upstream.
      if (in_flag_we && !in_is_branch) begin
        cc_d = '{z: in_z, v: in_v, n: in_n};
      end
      if (in_is_branch && cond_true) begin
        redirect_d    = 1'b1;
        redirect_pc_d = in_br_target;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      payload_q     <= '0;
      cc_q          <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      valid_q       <= valid_d;
      payload_q     <= payload_d;
      cc_q          <= cc_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_result     = payload_q.result;
  assign out_store_data = payload_q.store_data;
  assign out_rd         = payload_q.rd;
  // Side-effecting controls must never leak out of an empty stage.
  assign out_reg_we     = valid_q & payload_q.reg_we;
  assign out_mem_re     = valid_q & payload_q.mem_re;
  assign out_mem_we     = valid_q & payload_q.mem_we;
  assign cc_z           = cc_q.z;
  assign cc_v           = cc_q.v;
  assign cc_n           = cc_q.n;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef EX_MEM_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    taken_cnt_d = taken_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (valid_q && !out_ready) stall_cnt_d = stall_cnt_q + 16'd1;
    // Counted as the pulse is launched so the count matches the pulse cycle.
    if (redirect_d)            taken_cnt_d = taken_cnt_q + 16'd1;
    if (flush && valid_q)      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall = stall_cnt_q;
  assign perf_taken = taken_cnt_q;
  assign perf_flush = flush_cnt_q;
`endif

endmodule
